// File: rtl/card_deck_server_pkg.sv
// Shared card types, deck constants and the index-to-card mapping.
package card_deck_server_pkg;

    localparam int DECK_SIZE = 52;
    localparam int NUM_RANKS = 13;

    typedef enum logic [3:0] {
        TWO, THREE, FOUR, FIVE, SIX, SEVEN, EIGHT,
        NINE, TEN, JACK, QUEEN, KING, ACE
    } rank_t;

    typedef enum logic [1:0] {
        CLUBS, DIAMONDS, HEARTS, SPADES
    } suit_t;

    typedef struct packed {
        rank_t rank;
        suit_t suit;
    } card_t;

    // idx 0..51 -> rank = idx mod 13, suit = idx div 13 (idx 51 = Ace of Spades)
    function automatic card_t idx_to_card(input logic [5:0] idx);
        card_t c;
        c.rank = rank_t'(4'(idx % 6'(NUM_RANKS)));
        c.suit = suit_t'(2'(idx / 6'(NUM_RANKS)));
        return c;
    endfunction

endpackage

// File: rtl/card_deck_server_if.sv
// Card interface between the hand FSM (master) and the deck server (slave).
interface card_deck_server_if;
    import card_deck_server_pkg::*;

    logic       start_shuffle;
    logic       draw_card;
    card_t      top_card;
    logic       ready;
    logic [5:0] cards_left;
    logic       empty;

    modport master (
        output start_shuffle, draw_card,
        input  top_card, ready, cards_left, empty
    );

    modport slave (
        input  start_shuffle, draw_card,
        output top_card, ready, cards_left, empty
    );

endinterface

// File: rtl/card_deck_server_lfsr16.sv
// 16-bit Galois LFSR, free-running from reset. A zero seed would lock up,
// so it is replaced by 1.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] q
);

    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] r_q;

    // Right-shifting Galois step; taps fold in when the outgoing bit is 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= SEED_NZ;
        end else begin
            r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? TAPS : 16'h0000);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/card_deck_server.sv
// Deck server: holds a 52-card register deck, Fisher-Yates shuffles it with
// rejection-sampled LFSR indices and deals from the top on each draw.
//
// state | meaning
// IDLE  | waiting for the first start_shuffle
// INIT  | one cycle: deck reloaded in index order, ptr and i reset
// SHUF  | swap deck[i] with deck[rnd] whenever rnd <= i, walking i down to 1
// READY | dealing; ready=1, draws advance ptr up to 52
module card_deck_server
    import card_deck_server_pkg::*;
#(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter bit          SHUFFLE_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    card_deck_server_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, INIT, SHUF, READY} deck_state_t;

    deck_state_t r_state;
    deck_state_t w_next_state;

    logic [5:0]  r_deck [DECK_SIZE];
    logic [5:0]  r_ptr;
    logic [5:0]  r_i;

    logic [9:0]  w_lfsr_unused;
    logic [5:0]  w_rnd;
    logic        w_accept;
    logic        w_draw_ok;
    logic [5:0]  w_top_ptr;

    lfsr16 #(
        .SEED (SEED),
        .TAPS (16'hB400)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .q       ({w_lfsr_unused, w_rnd})
    );

    // Rejection sampling keeps the shuffle unbiased: out-of-range draws just retry.
    assign w_accept  = (w_rnd <= r_i);
    assign w_draw_ok = (r_state == READY) && bus.draw_card && !bus.start_shuffle
                       && (r_ptr < 6'(DECK_SIZE));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a start request pre-empts every state.
    always_comb begin
        w_next_state = r_state;
        if (bus.start_shuffle) begin
            w_next_state = INIT;
        end else begin
            case (r_state)
                IDLE:    w_next_state = IDLE;
                INIT:    w_next_state = SHUFFLE_EN ? SHUF : READY;
                SHUF:    if (w_accept && (r_i == 6'd1)) w_next_state = READY;
                READY:   w_next_state = READY;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Deck contents, deal pointer and shuffle index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DECK_SIZE; k++) r_deck[k] <= 6'(k);
            r_ptr <= '0;
            r_i   <= 6'(DECK_SIZE - 1);
        end else if (bus.start_shuffle) begin
            // Clearing ptr here makes a restart show a full deck immediately.
            r_ptr <= '0;
        end else begin
            case (r_state)
                INIT: begin
                    for (int k = 0; k < DECK_SIZE; k++) r_deck[k] <= 6'(k);
                    r_ptr <= '0;
                    r_i   <= 6'(DECK_SIZE - 1);
                end
                SHUF: begin
                    if (w_accept) begin
                        r_deck[r_i]   <= r_deck[w_rnd];
                        r_deck[w_rnd] <= r_deck[r_i];
                        if (r_i != 6'd1) r_i <= r_i - 6'd1;
                    end
                end
                READY: begin
                    if (w_draw_ok) r_ptr <= r_ptr + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Once the deck is exhausted the last card stays on show.
    assign w_top_ptr      = (r_ptr >= 6'(DECK_SIZE)) ? 6'(DECK_SIZE - 1) : r_ptr;
    assign bus.top_card   = idx_to_card(r_deck[w_top_ptr]);
    assign bus.ready      = (r_state == READY);
    assign bus.cards_left = 6'(DECK_SIZE) - r_ptr;
    assign bus.empty      = bus.ready && (bus.cards_left == 6'd0);

endmodule

// File: tb/tb_card_deck_server.sv
// Bench for card_deck_server: one unshuffled and one shuffled instance,
// checked against a behavioural Fisher-Yates model fed by its own LFSR copy.
module tb_card_deck_server;

    logic clk;
    logic r_rst_n;
    logic r_start;
    logic r_draw;
    logic r_sel;

    card_deck_server_if if0 ();
    card_deck_server_if if1 ();

    assign if0.start_shuffle = r_start & ~r_sel;
    assign if0.draw_card     = r_draw  & ~r_sel;
    assign if1.start_shuffle = r_start &  r_sel;
    assign if1.draw_card     = r_draw  &  r_sel;

    card_deck_server #(.SEED(16'hACE1), .SHUFFLE_EN(1'b0)) dut0 (
        .clk(clk), .reset_n(r_rst_n), .bus(if0)
    );
    card_deck_server #(.SEED(16'hACE1), .SHUFFLE_EN(1'b1)) dut1 (
        .clk(clk), .reset_n(r_rst_n), .bus(if1)
    );

    logic [5:0] w_top;
    logic [5:0] w_left;
    logic       w_ready;
    logic       w_empty;

    assign w_top   = r_sel ? if1.top_card   : if0.top_card;
    assign w_left  = r_sel ? if1.cards_left : if0.cards_left;
    assign w_ready = r_sel ? if1.ready      : if0.ready;
    assign w_empty = r_sel ? if1.empty      : if0.empty;

    int n_checks = 0;
    int n_err    = 0;
    int model_perm [52];
    bit seen [52];
    int seen_cnt;
    logic [15:0] m_lfsr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Reference LFSR: same seed, steps on every clock while out of reset.
    always @(posedge clk or negedge r_rst_n) begin
        if (!r_rst_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= lfsr_step(m_lfsr);
    end

    // Expected packed card {rank[3:0], suit[1:0]} for a deck index.
    function automatic int exp_card(input int idx);
        return ((idx % 13) << 2) | (idx / 13);
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Fisher-Yates with rejection: returns the cycle count spent shuffling.
    task automatic model_shuffle(input logic [15:0] seed, output int n);
        logic [15:0] l;
        int i, r, t;
        for (int k = 0; k < 52; k++) model_perm[k] = k;
        l = seed;
        i = 51;
        n = 0;
        while (i >= 1) begin
            r = int'(l[5:0]);
            n++;
            if (r <= i) begin
                t = model_perm[i];
                model_perm[i] = model_perm[r];
                model_perm[r] = t;
                i--;
            end
            l = lfsr_step(l);
        end
    endtask

    task automatic run_shuffle(input bit with_draw, input int stop_after);
        int n, k;
        @(negedge clk);
        r_start = 1'b1;
        r_draw  = with_draw;
        @(posedge clk); #1;
        check_eq("start_ready_drop", w_ready, 0);
        check_eq("start_cards_left", w_left, 52);
        @(negedge clk);
        r_start = 1'b0;
        r_draw  = 1'b0;
        @(posedge clk); #1;
        if (stop_after > 0) begin
            repeat (stop_after) @(posedge clk);
            #1;
            check_eq("abort_ready_low", w_ready, 0);
            return;
        end
        if (r_sel) begin
            model_shuffle(m_lfsr, n);
        end else begin
            for (int j = 0; j < 52; j++) model_perm[j] = j;
            n = 0;
        end
        k = 0;
        while (!w_ready && k < 4000) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("ready_latency", k, n);
    endtask

    task automatic draw_cards(input int first, input int cnt);
        int idx;
        if (first == 0) begin
            for (int j = 0; j < 52; j++) seen[j] = 1'b0;
            seen_cnt = 0;
        end
        for (int j = first; j < first + cnt; j++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            check_eq("top_card", w_top, exp_card(model_perm[j]));
            check_eq("cards_left", w_left, 52 - j);
            idx = int'(w_top[1:0]) * 13 + int'(w_top[5:2]);
            if (idx < 52 && !seen[idx]) begin
                seen[idx] = 1'b1;
                seen_cnt++;
            end
            @(negedge clk); r_draw = 1'b1;
            @(negedge clk); r_draw = 1'b0;
        end
    endtask

    task automatic deck_end_checks();
        check_eq("distinct_cards", seen_cnt, 52);
        check_eq("end_cards_left", w_left, 0);
        check_eq("end_empty", w_empty, 1);
        check_eq("end_top", w_top, exp_card(model_perm[51]));
        @(negedge clk); r_draw = 1'b1;
        @(negedge clk); r_draw = 1'b0;
        check_eq("extra_draw_top", w_top, exp_card(model_perm[51]));
        check_eq("extra_draw_left", w_left, 0);
        check_eq("extra_draw_empty", w_empty, 1);
    endtask

    initial begin
        r_rst_n = 1'b0;
        r_start = 1'b0;
        r_draw  = 1'b0;
        r_sel   = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            r_sel = s[0];
            #1;
            check_eq("rst_ready", w_ready, 0);
            check_eq("rst_cards_left", w_left, 52);
            check_eq("rst_empty", w_empty, 0);
            check_eq("rst_top", w_top, exp_card(0));
        end
        r_sel = 1'b0;
        repeat (3) @(negedge clk);
        r_rst_n = 1'b1;

        // Draw while IDLE is ignored.
        @(negedge clk); r_draw = 1'b1;
        @(negedge clk); r_draw = 1'b0;
        check_eq("idle_draw_left", w_left, 52);
        check_eq("idle_draw_ready", w_ready, 0);

        // Unshuffled deck deals in index order.
        run_shuffle(1'b0, 0);
        draw_cards(0, 52);
        deck_end_checks();

        // Shuffled deck after a random idle gap.
        r_sel = 1'b1;
        repeat ($urandom_range(1, 40)) @(negedge clk);
        run_shuffle(1'b0, 0);
        draw_cards(0, 52);
        deck_end_checks();

        // Restart in the middle of a shuffle.
        repeat ($urandom_range(0, 10)) @(negedge clk);
        run_shuffle(1'b0, 20);
        run_shuffle(1'b0, 0);
        draw_cards(0, 10);

        // Start and draw together in READY: the draw is discarded.
        run_shuffle(1'b1, 0);
        draw_cards(0, 3);

        // Asynchronous reset between clock edges while a draw is pending.
        @(negedge clk);
        r_draw = 1'b1;
        #2 r_rst_n = 1'b0;
        #1;
        check_eq("async_rst_ready", w_ready, 0);
        check_eq("async_rst_left", w_left, 52);
        check_eq("async_rst_top", w_top, exp_card(0));
        check_eq("async_rst_empty", w_empty, 0);
        r_draw = 1'b0;
        @(negedge clk);
        @(negedge clk);
        r_rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("post_rst_idle", w_ready, 0);
        run_shuffle(1'b0, 0);
        draw_cards(0, 5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/card_deck_server.md
Name: card_deck_server

Overview:
Deck-side responder for the hand FSM's card interface (start_shuffle / draw_card / top_card / ready).
- Holds a 52-entry register-array deck and randomises it with a Fisher-Yates shuffle driven by a free-running LFSR.
- Presents the current top card to the hand FSM and advances on each accepted draw.
- Sits beside poker_hand_fsm and is the only source of dealt cards.

Parameters:
SEED, 16'hACE1, LFSR reset value; must be nonzero, 0 is replaced by 16'h0001.
SHUFFLE_EN, 1, 0 = skip the swap phase so the deck stays in index order (bench/debug).

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
start_shuffle  input  1  single-cycle request: rebuild and reshuffle the deck
draw_card  input  1  consume top card; honoured only when ready=1 and cards_left>0
top_card  output  card_t  deck[ptr], muxed combinationally from registered state
ready  output  1  high only in READY state
cards_left  output  6  52 - ptr
empty  output  1  ready && cards_left==0

Behaviour:
Reset (async, reset_n=0):
- state=IDLE, ready=0, ptr=0, cards_left=52, empty=0.
- deck[k]=k for all k.
- top_card=index 0 card, i.e. {Two, suit 0}.
- LFSR=SEED.

Index mapping: idx 0..51 maps to rank=idx mod 13 (Two=0..Ace=12) and suit=idx div 13. So idx 51 = Ace of Spades.

LFSR:
- 16-bit Galois, taps 16'hB400.
- Steps every cycle from reset regardless of state, so user timing adds entropy.
- rnd = lfsr[5:0].

States:
- IDLE: wait for start_shuffle, then go to INIT.
- INIT: one cycle. deck[k]<=k for all k, ptr<=0, i<=51.
  - Next state is SHUF if SHUFFLE_EN, else READY.
- SHUF: each cycle, if rnd <= i (rejection sampling, unbiased):
  - swap deck[i] and deck[rnd];
  - if i==1, go to READY; otherwise i<=i-1.
  - If rnd > i, retry next cycle with no change.
- READY: ready=1.
  - draw_card && ptr<52 gives ptr<=ptr+1; top_card shows the next card in the following cycle.

Draw and restart rules:
- draw_card when ptr==52: ignored. ptr holds, top_card holds deck[51], empty=1.
- draw_card outside READY: ignored.
- start_shuffle in any state, including mid-SHUF or READY, goes to INIT next cycle. ready drops in that cycle.
- start_shuffle and draw_card in the same cycle: start wins, draw discarded.

Latency:
- With SHUFFLE_EN=0, ready rises 2 cycles after the start_shuffle edge.
- With SHUFFLE_EN=1, ready rises at least 53 cycles after the start_shuffle edge; it is variable because of rejection retries.
- A watchdog is not required, since a maximal-length LFSR guarantees eventual acceptance.

Invariant: deck is always a permutation of 0..51 after INIT.

Widths:
- ptr is 6-bit and saturates at 52.
- i is 6-bit.
- rnd is compared unsigned against i.

Reset asserted mid-SHUF or READY: immediate return to the reset values above.

Decomposition:
- In poker_types.svh / shared package:
  - card_t, rank_t and suit_t enums;
  - DECK_SIZE=52 and NUM_RANKS=13;
  - function idx_to_card(idx) implementing the mapping above.
- deck_state_t enum {IDLE, INIT, SHUF, READY} is local to the module.
- One natural sub-module: lfsr16 (params SEED, TAPS; ports clk, reset_n, q[15:0]), so it can be reused for other random choices.

Test Plan:
1. Reset, SHUFFLE_EN=0, pulse start_shuffle -> ready=1 two cycles later; top_card={Two,suit0}; cards_left=52.
2. SHUFFLE_EN=0, 52 single-cycle draws -> top_card walks idx 0..51 (last = Ace of Spades, idx 51); then cards_left=0, empty=1; 53rd draw leaves top_card=Ace of Spades.
3. SHUFFLE_EN=1, SEED=16'hACE1 -> ready rises at least 53 cycles after start; 52 draws yield 52 distinct indices; sequence matches the reference model seeded identically.
4. Pulse start_shuffle at cycle 20 of SHUF -> ready stays 0, state returns to INIT, a fresh permutation completes, cards_left=52.
5. In READY after 10 draws, assert start_shuffle and draw_card together -> draw ignored, ptr=0, ready=0 next cycle.
6. Drop reset_n asynchronously mid-draw (no clock edge) -> ready=0, cards_left=52, top_card={Two,suit0} immediately.
